s_mem_scheduler: RTL and testbench

S_MEM_SCHEDULER -- requirements
Module: s_mem_scheduler

---
 rtl/rc4_pkg.sv | 26 ++
 rtl/s_mem_scheduler_phase_timer.sv | 48 ++++
 rtl/s_mem_scheduler.sv | 205 ++++++++++++++++++++
 tb/tb_s_mem_scheduler.sv | 349 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rc4_pkg.sv
// ---------------------------------------------------------------------------
// rc4_pkg
// Shared definitions for the RC4 S-memory scheduler slice:
//   - phase_e      : scheduler phase encoding (also driven out on `phase`)
//   - REQ_*        : requester IDs (init / shuffle / decrypt)
//   - *_W_DEF      : default S-memory address / data widths
// ---------------------------------------------------------------------------
package rc4_pkg;

    localparam int ADDR_W_DEF = 8;
    localparam int DATA_W_DEF = 8;

    typedef enum logic [2:0] {
        PH_IDLE    = 3'd0,
        PH_INIT    = 3'd1,
        PH_SHUFFLE = 3'd2,
        PH_DECRYPT = 3'd3,
        PH_DONE    = 3'd4,
        PH_ERROR   = 3'd5
    } phase_e;

    localparam logic [1:0] REQ_INIT    = 2'd0;
    localparam logic [1:0] REQ_SHUFFLE = 2'd1;
    localparam logic [1:0] REQ_DECRYPT = 2'd2;

endpackage

// File: rtl/s_mem_scheduler_phase_timer.sv
// ---------------------------------------------------------------------------
// phase_timer
// Counts cycles spent in the current scheduler phase and flags the cycle in
// which the count would reach `limit`.
// Ports:
//   clk, reset_n : clock, asynchronous active-low reset
//   clear        : restart the count at zero (phase entry)
//   enable       : count this cycle (a phase is active)
//   limit        : number of phase cycles allowed
//   expired      : this enabled cycle is the limit-th cycle of the phase
// ---------------------------------------------------------------------------
module phase_timer #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             clear,
    input  logic             enable,
    input  logic [CNT_W-1:0] limit,
    output logic             expired
);

    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_d;
    logic [CNT_W:0]   count_inc;

    // Extra bit so the comparison cannot wrap at the counter's maximum.
    assign count_inc = {1'b0, count_q} + {{CNT_W{1'b0}}, 1'b1};
    assign expired   = enable & (count_inc >= {1'b0, limit});

    always_comb begin
        count_d = count_q;
        if (clear) begin
            count_d = '0;
        end else if (enable) begin
            count_d = count_inc[CNT_W-1:0];
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/s_mem_scheduler.sv
// ---------------------------------------------------------------------------
// s_mem_scheduler
// Sequences the RC4 init -> shuffle -> decrypt phases and arbitrates the
// single-port S-memory between the three phase FSMs. Ownership follows the
// phase; non-owner requests are dropped and flagged on `conflict`.
// Ports:
//   clk, reset_n                  : clock, asynchronous active-low reset
//   start                         : begin a new init/shuffle/decrypt run
//   start_<r> / done_<r>          : launch / completion pulses per phase FSM
//   req_<r>, wren_<r>,
//   address_<r>, data_<r>         : memory request from requester r
//   gnt_<r>                       : r owns the memory (its phase is active)
//   rvalid_<r>                    : rdata carries r's read data this cycle
//   mem_address/mem_data/mem_wren : to s_memory; mem_q back (1-cycle latency)
//   rdata                         : mem_q passed straight to all requesters
//   phase, busy, done, error      : scheduler status
//   conflict                      : a non-owner requested this cycle
// ---------------------------------------------------------------------------
module s_mem_scheduler
    import rc4_pkg::*;
#(
    parameter int          ADDR_W      = ADDR_W_DEF,
    parameter int          DATA_W      = DATA_W_DEF,
    parameter logic [15:0] TIMEOUT_CYC = 16'hFFFF
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              start,
    output logic              start_init,
    output logic              start_shuffle,
    output logic              start_decrypt,
    input  logic              done_init,
    input  logic              done_shuffle,
    input  logic              done_decrypt,
    input  logic              req_init,
    input  logic              wren_init,
    input  logic [ADDR_W-1:0] address_init,
    input  logic [DATA_W-1:0] data_init,
    input  logic              req_shuffle,
    input  logic              wren_shuffle,
    input  logic [ADDR_W-1:0] address_shuffle,
    input  logic [DATA_W-1:0] data_shuffle,
    input  logic              req_decrypt,
    input  logic              wren_decrypt,
    input  logic [ADDR_W-1:0] address_decrypt,
    input  logic [DATA_W-1:0] data_decrypt,
    output logic              gnt_init,
    output logic              gnt_shuffle,
    output logic              gnt_decrypt,
    output logic              rvalid_init,
    output logic              rvalid_shuffle,
    output logic              rvalid_decrypt,
    output logic [ADDR_W-1:0] mem_address,
    output logic [DATA_W-1:0] mem_data,
    output logic              mem_wren,
    input  logic [DATA_W-1:0] mem_q,
    output logic [DATA_W-1:0] rdata,
    output logic [2:0]        phase,
    output logic              busy,
    output logic              done,
    output logic              error,
    output logic              conflict
);

    localparam logic [2:0] ST_IDLE    = PH_IDLE;
    localparam logic [2:0] ST_INIT    = PH_INIT;
    localparam logic [2:0] ST_SHUFFLE = PH_SHUFFLE;
    localparam logic [2:0] ST_DECRYPT = PH_DECRYPT;
    localparam logic [2:0] ST_DONE    = PH_DONE;
    localparam logic [2:0] ST_ERROR   = PH_ERROR;

    logic [2:0] state_q, state_d;
    logic       launch_q;      // first cycle of the current state
    logic       rd_pend_q;     // owner read issued last cycle
    logic [1:0] rd_id_q;       // who issued it (survives a phase change)

    logic       own_valid;
    logic [1:0] own_id;
    logic       own_req, own_wren, own_read;
    logic [2:0] req_v, gnt_v;
    logic       expired;

    assign req_v = {req_decrypt, req_shuffle, req_init};

    // Phase -> memory owner.
    always_comb begin
        own_valid = 1'b1;
        own_id    = REQ_INIT;
        case (state_q)
            ST_INIT:    own_id = REQ_INIT;
            ST_SHUFFLE: own_id = REQ_SHUFFLE;
            ST_DECRYPT: own_id = REQ_DECRYPT;
            default:    own_valid = 1'b0;
        endcase
    end

    assign gnt_v = own_valid ? (3'b001 << own_id) : 3'b000;

    // Memory mux: only the owner's request reaches s_memory.
    always_comb begin
        // NOTE: every output gets a default before the case, so no path can infer a latch.
        mem_address = '0;
        mem_data    = '0;
        own_req     = 1'b0;
        own_wren    = 1'b0;
        if (own_valid) begin
            case (own_id)
                REQ_INIT: begin
                    mem_address = address_init;
                    mem_data    = data_init;
                    own_req     = req_init;
                    own_wren    = wren_init;
                end
                REQ_SHUFFLE: begin
                    mem_address = address_shuffle;
                    mem_data    = data_shuffle;
                    own_req     = req_shuffle;
                    own_wren    = wren_shuffle;
                end
                default: begin
                    mem_address = address_decrypt;
                    mem_data    = data_decrypt;
                    own_req     = req_decrypt;
                    own_wren    = wren_decrypt;
                end
            endcase
        end
    end

    assign mem_wren = own_req & own_wren;
    assign own_read = own_req & ~own_wren;

    // Qualified by reset_n so the flag is low while reset is held even if
    // requesters keep asserting req.
    assign conflict = reset_n & (|(req_v & ~gnt_v));

    // Phase sequencing; a timeout takes priority over a same-cycle done.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE, ST_DONE, ST_ERROR: begin
                if (start) state_d = ST_INIT;
            end
            ST_INIT: begin
                if (expired)        state_d = ST_ERROR;
                else if (done_init) state_d = ST_SHUFFLE;
            end
            ST_SHUFFLE: begin
                if (expired)           state_d = ST_ERROR;
                else if (done_shuffle) state_d = ST_DECRYPT;
            end
            ST_DECRYPT: begin
                if (expired)           state_d = ST_ERROR;
                else if (done_decrypt) state_d = ST_DONE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    phase_timer #(
        .CNT_W (16)
    ) u_phase_timer (
        .clk     (clk),
        .reset_n (reset_n),
        .clear   (state_d != state_q),
        .enable  (own_valid),
        .limit   (TIMEOUT_CYC),
        .expired (expired)
    );

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= ST_IDLE;
            launch_q  <= 1'b0;
            rd_pend_q <= 1'b0;
            rd_id_q   <= REQ_INIT;
        end else begin
            state_q   <= state_d;
            launch_q  <= (state_d != state_q);
            rd_pend_q <= own_read;
            if (own_read) rd_id_q <= own_id;
        end
    end

    // Launch pulse only for phase states; DONE/ERROR have no grant.
    assign start_init    = launch_q & gnt_v[0];
    assign start_shuffle = launch_q & gnt_v[1];
    assign start_decrypt = launch_q & gnt_v[2];

    assign gnt_init    = gnt_v[0];
    assign gnt_shuffle = gnt_v[1];
    assign gnt_decrypt = gnt_v[2];

    assign rvalid_init    = rd_pend_q & (rd_id_q == REQ_INIT);
    assign rvalid_shuffle = rd_pend_q & (rd_id_q == REQ_SHUFFLE);
    assign rvalid_decrypt = rd_pend_q & (rd_id_q == REQ_DECRYPT);

    assign rdata = mem_q;
    assign phase = state_q;
    assign busy  = own_valid;
    assign done  = (state_q == ST_DONE);
    assign error = (state_q == ST_ERROR);

endmodule

// File: tb/tb_s_mem_scheduler.sv
// ---------------------------------------------------------------------------
// tb_s_mem_scheduler
// Two instances share all inputs: u_dut (TIMEOUT_CYC=16) is checked every
// cycle against a cycle-level reference model; u_long (default timeout)
// runs the long init/shuffle/decrypt sequence. A behavioural s_memory with
// one cycle of read latency sits on u_dut's memory port.
// ---------------------------------------------------------------------------
module tb_s_mem_scheduler;
    import rc4_pkg::*;

    localparam logic [15:0] SHORT_TO = 16'd16;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic       start = 1'b0;
    logic [2:0] req = '0, wren = '0, done_in = '0;
    logic [7:0] addr [3];
    logic [7:0] wdata [3];

    // u_dut outputs
    logic [2:0] d_start, d_gnt, d_rvalid, d_phase;
    logic [7:0] d_mem_address, d_mem_data, d_rdata;
    logic       d_mem_wren, d_busy, d_done, d_error, d_conflict;
    // u_long outputs
    logic [2:0] l_start, l_gnt, l_rvalid, l_phase;
    logic [7:0] l_mem_address, l_mem_data, l_rdata;
    logic       l_mem_wren, l_busy, l_done, l_error, l_conflict;

    // s_memory model
    logic [7:0] mem [256];
    logic [7:0] mem_q;
    logic       mem_clr = 1'b1;

    always @(posedge clk) begin
        if (mem_clr) begin
            for (int i = 0; i < 256; i++) mem[i] <= 8'h00;
        end else if (d_mem_wren) begin
            mem[d_mem_address] <= d_mem_data;
        end
        mem_q <= mem[d_mem_address];
    end

    always #5 clk = ~clk;

    s_mem_scheduler #(.ADDR_W(8), .DATA_W(8), .TIMEOUT_CYC(SHORT_TO)) u_dut (
        .clk(clk), .reset_n(reset_n), .start(start),
        .start_init(d_start[0]), .start_shuffle(d_start[1]), .start_decrypt(d_start[2]),
        .done_init(done_in[0]), .done_shuffle(done_in[1]), .done_decrypt(done_in[2]),
        .req_init(req[0]), .wren_init(wren[0]), .address_init(addr[0]), .data_init(wdata[0]),
        .req_shuffle(req[1]), .wren_shuffle(wren[1]), .address_shuffle(addr[1]), .data_shuffle(wdata[1]),
        .req_decrypt(req[2]), .wren_decrypt(wren[2]), .address_decrypt(addr[2]), .data_decrypt(wdata[2]),
        .gnt_init(d_gnt[0]), .gnt_shuffle(d_gnt[1]), .gnt_decrypt(d_gnt[2]),
        .rvalid_init(d_rvalid[0]), .rvalid_shuffle(d_rvalid[1]), .rvalid_decrypt(d_rvalid[2]),
        .mem_address(d_mem_address), .mem_data(d_mem_data), .mem_wren(d_mem_wren),
        .mem_q(mem_q), .rdata(d_rdata), .phase(d_phase),
        .busy(d_busy), .done(d_done), .error(d_error), .conflict(d_conflict)
    );

    s_mem_scheduler u_long (
        .clk(clk), .reset_n(reset_n), .start(start),
        .start_init(l_start[0]), .start_shuffle(l_start[1]), .start_decrypt(l_start[2]),
        .done_init(done_in[0]), .done_shuffle(done_in[1]), .done_decrypt(done_in[2]),
        .req_init(req[0]), .wren_init(wren[0]), .address_init(addr[0]), .data_init(wdata[0]),
        .req_shuffle(req[1]), .wren_shuffle(wren[1]), .address_shuffle(addr[1]), .data_shuffle(wdata[1]),
        .req_decrypt(req[2]), .wren_decrypt(wren[2]), .address_decrypt(addr[2]), .data_decrypt(wdata[2]),
        .gnt_init(l_gnt[0]), .gnt_shuffle(l_gnt[1]), .gnt_decrypt(l_gnt[2]),
        .rvalid_init(l_rvalid[0]), .rvalid_shuffle(l_rvalid[1]), .rvalid_decrypt(l_rvalid[2]),
        .mem_address(l_mem_address), .mem_data(l_mem_data), .mem_wren(l_mem_wren),
        .mem_q(mem_q), .rdata(l_rdata), .phase(l_phase),
        .busy(l_busy), .done(l_done), .error(l_error), .conflict(l_conflict)
    );

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // ---------------- reference model ----------------
    phase_e     m_phase;
    int         m_cyc;       // cycles already spent in the current phase
    bit         m_first;     // current state was just entered
    bit         m_rv;
    int         m_rv_id;
    logic [7:0] m_rv_data;
    logic [7:0] shadow [256];

    function automatic int owner_of(input phase_e p);
        case (p)
            PH_INIT:    return 0;
            PH_SHUFFLE: return 1;
            PH_DECRYPT: return 2;
            default:    return -1;
        endcase
    endfunction

    task automatic model_reset();
        m_phase = PH_IDLE;
        m_cyc   = 0;
        m_first = 1'b0;
        m_rv    = 1'b0;
    endtask

    task automatic model_update();
        int     o;
        phase_e nxt;
        if (!reset_n) begin
            model_reset();
            return;
        end
        o    = owner_of(m_phase);
        m_rv = 1'b0;
        if (o >= 0) begin
            if (req[o] && wren[o]) begin
                shadow[addr[o]] = wdata[o];
            end else if (req[o]) begin
                m_rv      = 1'b1;
                m_rv_id   = o;
                m_rv_data = shadow[addr[o]];
            end
        end
        nxt = m_phase;
        if (o >= 0) begin
            m_cyc++;
            if (m_cyc >= int'(SHORT_TO)) nxt = PH_ERROR;
            else if (done_in[o])         nxt = (o == 0) ? PH_SHUFFLE : (o == 1) ? PH_DECRYPT : PH_DONE;
        end else if (start) begin
            nxt = PH_INIT;
        end
        m_first = (nxt != m_phase);
        if (nxt != m_phase) m_cyc = 0;
        m_phase = nxt;
    endtask

    task automatic compare_all();
        int         o;
        logic [2:0] g_exp;
        logic [7:0] a_exp, dt_exp;
        logic       w_exp;
        o      = owner_of(m_phase);
        g_exp  = 3'b000;
        a_exp  = 8'h00;
        dt_exp = 8'h00;
        w_exp  = 1'b0;
        if (o >= 0) begin
            g_exp  = 3'(1 << o);
            a_exp  = addr[o];
            dt_exp = wdata[o];
            w_exp  = req[o] & wren[o];
        end
        check("phase",    d_phase, m_phase);
        check("gnt",      d_gnt, g_exp);
        check("start_r",  d_start, m_first ? g_exp : 3'b000);
        check("rvalid",   d_rvalid, m_rv ? 3'(1 << m_rv_id) : 3'b000);
        check("mem_addr", d_mem_address, a_exp);
        check("mem_data", d_mem_data, dt_exp);
        check("mem_wren", d_mem_wren, w_exp);
        check("conflict", d_conflict, reset_n & (|(req & ~g_exp)));
        check("busy",     d_busy, o >= 0);
        check("done",     d_done, m_phase == PH_DONE);
        check("error",    d_error, m_phase == PH_ERROR);
        if (m_rv) check("rdata", d_rdata, m_rv_data);
    endtask

    // Called just after a falling edge with inputs already driven.
    task automatic step();
        if (!reset_n) model_reset();
        #1;
        compare_all();
        @(posedge clk);
        model_update();
        @(negedge clk);
    endtask

    task automatic clear_inputs();
        start   = 1'b0;
        req     = '0;
        wren    = '0;
        done_in = '0;
        for (int i = 0; i < 3; i++) begin
            addr[i]  = 8'h00;
            wdata[i] = 8'h00;
        end
    endtask

    // ---------------- long-sequence expectations ----------------
    phase_e exp_seq [4] = '{PH_INIT, PH_SHUFFLE, PH_DECRYPT, PH_DONE};
    int     exp_cyc [4] = '{1, 261, 1801, 1901};

    initial begin
        int         seen;
        logic [2:0] prev;
        int         st_cnt [3];
        int         st_cyc [3];

        for (int i = 0; i < 256; i++) shadow[i] = 8'h00;
        clear_inputs();
        model_reset();
        reset_n = 1'b0;
        repeat (2) @(negedge clk);
        mem_clr = 1'b0;

        // Reset state
        step();
        check("long_rst_phase", l_phase, PH_IDLE);
        reset_n = 1'b1;
        repeat (4) step();   // no action without start

        // Long run on u_long: done pulses at cycles 260 / 1800 / 1900 after start
        seen = 0;
        prev = l_phase;
        for (int i = 0; i < 3; i++) begin
            st_cnt[i] = 0;
            st_cyc[i] = -1;
        end
        for (int c = 0; c < 1950; c++) begin
            start   = (c == 0);
            done_in = {c == 1900, c == 1800, c == 260};
            #1;
            if (l_phase != prev) begin
                if (seen < 4) begin
                    check("seq_phase", l_phase, exp_seq[seen]);
                    check("seq_cycle", c, exp_cyc[seen]);
                end
                seen++;
                prev = l_phase;
            end
            for (int r = 0; r < 3; r++) begin
                if (l_start[r]) begin
                    st_cnt[r]++;
                    st_cyc[r] = c;
                end
            end
            @(negedge clk);
        end
        clear_inputs();
        check("seq_count", seen, 4);
        for (int r = 0; r < 3; r++) begin
            check("start_pulses", st_cnt[r], 1);
            check("start_cycle", st_cyc[r], exp_cyc[r]);
        end
        check("long_done", l_done, 1'b1);
        check("long_busy", l_busy, 1'b0);

        // Re-sync u_dut with the model
        reset_n = 1'b0;
        step();
        reset_n = 1'b1;
        step();

        // Shuffle reads 05 while init tries to write 05
        start = 1'b1; step(); start = 1'b0;
        step();
        done_in[0] = 1'b1; step(); done_in = '0;
        req[1] = 1'b1; wren[1] = 1'b0; addr[1] = 8'h05;
        req[0] = 1'b1; wren[0] = 1'b1; addr[0] = 8'h05; wdata[0] = 8'hA5;
        #1;
        check("c34_addr", d_mem_address, 8'h05);
        check("c34_wren", d_mem_wren, 1'b0);
        check("c34_conflict", d_conflict, 1'b1);
        step();
        clear_inputs();
        #1;
        check("c34_rvalid", d_rvalid, 3'b010);
        check("c34_rdata", d_rdata, 8'h00);
        check("c34_mem", mem[5], 8'h00);
        step();

        // Init read on the same cycle as done_init
        done_in[1] = 1'b1; step(); done_in = '0;
        done_in[2] = 1'b1; step(); done_in = '0;
        start = 1'b1; step(); start = 1'b0;
        req[0] = 1'b1; wren[0] = 1'b0; addr[0] = 8'hFF; done_in[0] = 1'b1;
        step();
        clear_inputs();
        #1;
        check("c35_rvalid", d_rvalid, 3'b001);
        check("c35_phase", d_phase, PH_SHUFFLE);
        check("c35_start", d_start, 3'b010);
        step();

        // Timeout in INIT after 16 cycles
        done_in[1] = 1'b1; step(); done_in = '0;
        done_in[2] = 1'b1; step(); done_in = '0;
        start = 1'b1; step(); start = 1'b0;
        for (int i = 0; i < 16; i++) begin
            #1;
            check("c36_init", d_phase, PH_INIT);
            step();
        end
        #1;
        check("c36_phase", d_phase, PH_ERROR);
        check("c36_error", d_error, 1'b1);
        check("c36_gnt", d_gnt, 3'b000);
        step();
        start = 1'b1; step(); start = 1'b0;
        #1;
        check("c36_restart", d_phase, PH_INIT);
        check("c36_err_clr", d_error, 1'b0);
        step();

        // Start ignored while busy; reset in DECRYPT during a write
        done_in[0] = 1'b1; step(); done_in = '0;
        done_in[1] = 1'b1; step(); done_in = '0;
        start = 1'b1; step(); start = 1'b0;
        #1;
        check("c37_ignore", d_phase, PH_DECRYPT);
        req[2] = 1'b1; wren[2] = 1'b1; addr[2] = 8'h03; wdata[2] = 8'h77;
        #1;
        check("c37_wr_pre", d_mem_wren, 1'b1);
        reset_n = 1'b0;
        #1;
        check("c37_wren", d_mem_wren, 1'b0);
        check("c37_phase", d_phase, PH_IDLE);
        check("c37_outs", {d_start, d_gnt, d_rvalid, d_busy, d_done, d_error, d_conflict}, 13'h0);
        check("c37_addr", d_mem_address, 8'h00);
        step();
        check("c37_mem", mem[3], 8'h00);
        reset_n = 1'b1;
        clear_inputs();
        step();

        // Randomized traffic against the model
        for (int n = 0; n < 800; n++) begin
            start   = ($urandom_range(0, 9) == 0);
            done_in = {$urandom_range(0, 5) == 0, $urandom_range(0, 5) == 0, $urandom_range(0, 5) == 0};
            req     = 3'($urandom);
            wren    = 3'($urandom);
            for (int r = 0; r < 3; r++) begin
                addr[r]  = 8'($urandom_range(0, 7));
                wdata[r] = 8'($urandom);
            end
            reset_n = ($urandom_range(0, 127) != 0);
            step();
        end
        reset_n = 1'b1;
        clear_inputs();
        step();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
